// File: rtl/csr_trap_if.sv
// Bundle of pipeline-facing trap, CSR access and status signals for csr_trap_unit.
interface csr_trap_if;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] csr_era;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic        va_error;
  logic [31:0] bad_va;
  logic        csr_wr_en;
  logic [13:0] wr_csr_addr;
  logic [31:0] wr_csr_data;
  logic        ws_llbit_set;
  logic        ws_llbit;
  logic [7:0]  hw_int;
  logic [13:0] rd_csr_addr;
  logic [31:0] rd_csr_data;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        has_int;
  logic        llbit;
  logic [1:0]  plv;

  modport master (
    output excp_flush, ertn_flush, csr_era, csr_ecode, csr_esubcode, va_error, bad_va,
           csr_wr_en, wr_csr_addr, wr_csr_data, ws_llbit_set, ws_llbit, hw_int, rd_csr_addr,
    input  rd_csr_data, ex_entry, ertn_pc, has_int, llbit, plv
  );

  modport slave (
    input  excp_flush, ertn_flush, csr_era, csr_ecode, csr_esubcode, va_error, bad_va,
           csr_wr_en, wr_csr_addr, wr_csr_data, ws_llbit_set, ws_llbit, hw_int, rd_csr_addr,
    output rd_csr_data, ex_entry, ertn_pc, has_int, llbit, plv
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Privileged CSR file with exception/ertn entry, interrupt status, LL bit and countdown timer.
module csr_trap_unit (
  input  logic       clk,
  input  logic       reset,
  csr_trap_if.slave  bus
);
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;
  localparam logic [13:0] CSR_LLBCTL = 14'h060;

  logic [1:0]  crmd_plv;
  logic        crmd_ie, crmd_da, crmd_pg;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_timer;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era, badv;
  logic [25:0] eentry_hi;
  logic [31:0] tcfg, tval;
  logic        llb_klo, llbit_q;

  logic        csr_we, wr_tcfg, wr_ticlr, timer_expire;
  logic [12:0] estat_is;
  logic [31:0] estat_word;
  logic [31:0] rd_data;

  // Flushes squash the CSR write issued in the same cycle.
  assign csr_we       = bus.csr_wr_en & ~bus.excp_flush & ~bus.ertn_flush;
  assign wr_tcfg      = csr_we && (bus.wr_csr_addr == CSR_TCFG);
  assign wr_ticlr     = csr_we && (bus.wr_csr_addr == CSR_TICLR);
  assign timer_expire = ~wr_tcfg & tcfg[0] & (tval == 32'd1);

  assign estat_is   = {1'b0, is_timer, 1'b0, is_hw, is_sw};
  assign estat_word = {1'b0, esubcode, ecode, 3'b000, estat_is};

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv  <= '0;
      crmd_ie   <= 1'b0;
      crmd_da   <= 1'b1;
      crmd_pg   <= 1'b0;
      prmd_pplv <= '0;
      prmd_pie  <= 1'b0;
      ecfg_lie  <= '0;
      is_sw     <= '0;
      is_hw     <= '0;
      is_timer  <= 1'b0;
      ecode     <= '0;
      esubcode  <= '0;
      era       <= '0;
      badv      <= '0;
      eentry_hi <= '0;
      tcfg      <= '0;
      tval      <= '0;
      llb_klo   <= 1'b0;
      llbit_q   <= 1'b0;
    end else begin
      is_hw <= bus.hw_int;

      if (wr_tcfg) begin
        tcfg <= bus.wr_csr_data;
        tval <= {bus.wr_csr_data[31:2], 2'b00};
      end else if (tcfg[0] && (tval != '0)) begin
        if (tval == 32'd1) tval <= tcfg[1] ? {tcfg[31:2], 2'b00} : '0;
        else               tval <= tval - 32'd1;
      end

      // Expiry outranks a simultaneous TICLR clear.
      if (timer_expire)                         is_timer <= 1'b1;
      else if (wr_ticlr && bus.wr_csr_data[0])  is_timer <= 1'b0;

      if (bus.excp_flush) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
        crmd_plv  <= '0;
        crmd_ie   <= 1'b0;
        era       <= bus.csr_era;
        ecode     <= bus.csr_ecode;
        esubcode  <= bus.csr_esubcode;
        if (bus.va_error) badv <= bus.bad_va;
      end else if (bus.ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
        if (llb_klo) llb_klo <= 1'b0;
        else         llbit_q <= 1'b0;
      end else if (csr_we) begin
        case (bus.wr_csr_addr)
          CSR_CRMD:   {crmd_pg, crmd_da, crmd_ie, crmd_plv} <= bus.wr_csr_data[4:0];
          CSR_PRMD:   {prmd_pie, prmd_pplv} <= bus.wr_csr_data[2:0];
          CSR_ECFG:   ecfg_lie <= {bus.wr_csr_data[12:11], 1'b0, bus.wr_csr_data[9:0]};
          CSR_ESTAT:  is_sw <= bus.wr_csr_data[1:0];
          CSR_ERA:    era <= bus.wr_csr_data;
          CSR_BADV:   badv <= bus.wr_csr_data;
          CSR_EENTRY: eentry_hi <= bus.wr_csr_data[31:6];
          CSR_LLBCTL: begin
            if (bus.wr_csr_data[1]) llbit_q <= 1'b0;
            llb_klo <= bus.wr_csr_data[2];
          end
          default: ;
        endcase
      end

      // Writeback-stage LL/SC update takes precedence over any clear above.
      if (bus.ws_llbit_set) llbit_q <= bus.ws_llbit;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.rd_csr_addr)
      CSR_CRMD:   rd_data = {27'b0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD:   rd_data = {29'b0, prmd_pie, prmd_pplv};
      CSR_ECFG:   rd_data = {19'b0, ecfg_lie};
      CSR_ESTAT:  rd_data = estat_word;
      CSR_ERA:    rd_data = era;
      CSR_BADV:   rd_data = badv;
      CSR_EENTRY: rd_data = {eentry_hi, 6'b0};
      CSR_TCFG:   rd_data = tcfg;
      CSR_TVAL:   rd_data = tval;
      CSR_LLBCTL: rd_data = {29'b0, llb_klo, 1'b0, llbit_q};
      default:    rd_data = '0;
    endcase
  end

  assign bus.rd_csr_data = rd_data;
  assign bus.ex_entry    = {eentry_hi, 6'b0};
  assign bus.ertn_pc     = era;
  assign bus.plv         = crmd_plv;
  assign bus.llbit       = llbit_q;
  assign bus.has_int     = crmd_ie & |(estat_is & ecfg_lie);
endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: directed trap/timer scenarios then random traffic vs a word-level model.
module tb_csr_trap_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csr_trap_if bus ();
  csr_trap_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Whole-register architectural state
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry, m_tcfg, m_tval;
  logic        m_klo, m_llbit;

  task automatic model_reset();
    m_crmd = 32'h8; m_prmd = '0; m_ecfg = '0; m_estat = '0; m_era = '0; m_badv = '0;
    m_eentry = '0; m_tcfg = '0; m_tval = '0; m_klo = 1'b0; m_llbit = 1'b0;
  endtask

  function automatic logic [31:0] model_rd(input logic [13:0] a);
    case (a)
      14'h000: return m_crmd;
      14'h001: return m_prmd;
      14'h004: return m_ecfg;
      14'h005: return m_estat;
      14'h006: return m_era;
      14'h007: return m_badv;
      14'h00c: return m_eentry;
      14'h041: return m_tcfg;
      14'h042: return m_tval;
      14'h060: return {29'b0, m_klo, 1'b0, m_llbit};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] crmd, prmd, ecfg, estat, era, badv, eentry, tcfg, tval, d;
    logic        klo, llb, we;
    if (reset) begin
      model_reset();
    end else begin
      crmd = m_crmd; prmd = m_prmd; ecfg = m_ecfg; estat = m_estat; era = m_era; badv = m_badv;
      eentry = m_eentry; tcfg = m_tcfg; tval = m_tval; klo = m_klo; llb = m_llbit;
      d  = bus.wr_csr_data;
      we = bus.csr_wr_en && !bus.excp_flush && !bus.ertn_flush;
      estat = (estat & ~32'h3fc) | (32'(bus.hw_int) << 2);
      if (bus.excp_flush) begin
        prmd  = m_crmd & 32'h7;
        crmd  = m_crmd & ~32'h7;
        era   = bus.csr_era;
        estat = (estat & ~32'h7fff0000) | (32'(bus.csr_ecode) << 16) | (32'(bus.csr_esubcode) << 22);
        if (bus.va_error) badv = bus.bad_va;
      end else if (bus.ertn_flush) begin
        crmd = (m_crmd & ~32'h7) | (m_prmd & 32'h7);
        if (m_klo) klo = 1'b0; else llb = 1'b0;
      end else if (we) begin
        case (bus.wr_csr_addr)
          14'h000: crmd = d & 32'h1f;
          14'h001: prmd = d & 32'h7;
          14'h004: ecfg = d & 32'h1bff;
          14'h005: estat = (estat & ~32'h3) | (d & 32'h3);
          14'h006: era = d;
          14'h007: badv = d;
          14'h00c: eentry = d & 32'hffffffc0;
          14'h041: tcfg = d;
          14'h044: if (d[0]) estat = estat & ~32'h800;
          14'h060: begin if (d[1]) llb = 1'b0; klo = d[2]; end
          default: ;
        endcase
      end
      if (we && bus.wr_csr_addr == 14'h041) tval = d & ~32'h3;
      else if (m_tcfg[0] && m_tval != 0) begin
        if (m_tval == 1) begin
          estat = estat | 32'h800;
          tval  = m_tcfg[1] ? (m_tcfg & ~32'h3) : 32'h0;
        end else tval = m_tval - 1;
      end
      if (bus.ws_llbit_set) llb = bus.ws_llbit;
      m_crmd = crmd; m_prmd = prmd; m_ecfg = ecfg; m_estat = estat; m_era = era; m_badv = badv;
      m_eentry = eentry; m_tcfg = tcfg; m_tval = tval; m_klo = klo; m_llbit = llb;
    end
  endtask

  function automatic logic model_has_int();
    return m_crmd[2] && ((m_estat & m_ecfg & 32'h1fff) != 0);
  endfunction

  task automatic expect_rd(input string name, input logic [13:0] a, input logic [31:0] mask,
                           input logic [31:0] exp);
    bus.rd_csr_addr = a;
    sb.push_back('{name, 0, mask, exp});
  endtask

  task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
    sb.push_back('{name, sel, 32'hffffffff, exp});
  endtask

  task automatic push_model();
    sb.push_back('{"m_rd",      0, 32'hffffffff, model_rd(bus.rd_csr_addr)});
    sb.push_back('{"m_ex_entry",1, 32'hffffffff, m_eentry});
    sb.push_back('{"m_ertn_pc", 2, 32'hffffffff, m_era});
    sb.push_back('{"m_has_int", 3, 32'hffffffff, {31'b0, model_has_int()}});
    sb.push_back('{"m_llbit",   4, 32'hffffffff, {31'b0, m_llbit}});
    sb.push_back('{"m_plv",     5, 32'hffffffff, m_crmd & 32'h3});
  endtask

  task automatic do_cycle();
    push_model();
    @(posedge clk);
    model_step();
    #1;
    reset = 1'b0; bus.excp_flush = 1'b0; bus.ertn_flush = 1'b0; bus.csr_wr_en = 1'b0;
    bus.ws_llbit_set = 1'b0; bus.va_error = 1'b0;
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    bus.csr_wr_en = 1'b1; bus.wr_csr_addr = a; bus.wr_csr_data = d;
    do_cycle();
  endtask

  // Monitor: compares everything queued for the current cycle against live DUT outputs
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.sel)
          0:       act = bus.rd_csr_data;
          1:       act = bus.ex_entry;
          2:       act = bus.ertn_pc;
          3:       act = {31'b0, bus.has_int};
          4:       act = {31'b0, bus.llbit};
          default: act = {30'b0, bus.plv};
        endcase
        n_checks++;
        if ((act & e.mask) !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (rd_addr %h, t=%0t)", e.name, act & e.mask,
                   e.exp, bus.rd_csr_addr, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [13:0] addrs [12] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                              14'h00c, 14'h041, 14'h042, 14'h044, 14'h060, 14'h099};

  initial begin
    reset = 1'b1;
    bus.excp_flush = 0; bus.ertn_flush = 0; bus.csr_era = '0; bus.csr_ecode = '0;
    bus.csr_esubcode = '0; bus.va_error = 0; bus.bad_va = '0; bus.csr_wr_en = 0;
    bus.wr_csr_addr = '0; bus.wr_csr_data = '0; bus.ws_llbit_set = 0; bus.ws_llbit = 0;
    bus.hw_int = '0; bus.rd_csr_addr = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;

    expect_rd("crmd_reset", 14'h000, 32'hffffffff, 32'h8);
    expect_out("plv_reset", 5, 0);
    expect_out("llbit_reset", 4, 0);
    expect_out("ex_entry_reset", 1, 0);
    do_cycle();
    expect_rd("tval_reset", 14'h042, 32'hffffffff, 0);
    do_cycle();

    // Trap entry and return
    expect_rd("crmd_read_during_write", 14'h000, 32'hffffffff, 32'h8);
    csr_write(14'h000, 32'h7);
    expect_rd("crmd_after_write", 14'h000, 32'hffffffff, 32'h7);
    bus.ws_llbit_set = 1; bus.ws_llbit = 1;
    do_cycle();
    expect_out("llbit_set", 4, 1);
    bus.excp_flush = 1; bus.csr_ecode = 6'h0b; bus.csr_esubcode = '0;
    bus.csr_era = 32'h1c000100; bus.va_error = 0; bus.bad_va = 32'h12345678;
    do_cycle();
    expect_rd("crmd_after_excp", 14'h000, 32'h7, 0);
    expect_out("plv_after_excp", 5, 0);
    do_cycle();
    expect_rd("prmd_after_excp", 14'h001, 32'hffffffff, 32'h7);
    do_cycle();
    expect_rd("era_after_excp", 14'h006, 32'hffffffff, 32'h1c000100);
    do_cycle();
    expect_rd("ecode_after_excp", 14'h005, 32'h003f0000, 32'h000b0000);
    do_cycle();
    expect_rd("badv_unchanged", 14'h007, 32'hffffffff, 0);
    bus.ertn_flush = 1;
    do_cycle();
    expect_out("plv_after_ertn", 5, 3);
    expect_out("llbit_after_ertn", 4, 0);
    expect_out("ertn_pc", 2, 32'h1c000100);
    expect_rd("crmd_after_ertn", 14'h000, 32'h7, 32'h7);
    do_cycle();

    // Periodic timer, interrupt and TICLR
    csr_write(14'h004, 32'h800);
    csr_write(14'h000, 32'h4);
    csr_write(14'h041, 32'h0000000b);
    expect_rd("tval_loaded", 14'h042, 32'hffffffff, 32'h8);
    do_cycle();
    repeat (6) do_cycle();
    expect_rd("tval_at_one", 14'h042, 32'hffffffff, 32'h1);
    expect_out("has_int_before_expiry", 3, 0);
    do_cycle();
    expect_rd("tval_reloaded", 14'h042, 32'hffffffff, 32'h8);
    expect_out("has_int_after_expiry", 3, 1);
    do_cycle();
    expect_rd("estat_timer_set", 14'h005, 32'h800, 32'h800);
    do_cycle();
    csr_write(14'h000, 32'h0);
    expect_out("has_int_ie_off", 3, 0);
    expect_rd("ticlr_reads_zero", 14'h044, 32'hffffffff, 0);
    do_cycle();
    csr_write(14'h044, 32'h1);
    expect_rd("estat_timer_cleared", 14'h005, 32'h800, 0);
    do_cycle();
    csr_write(14'h041, 32'h0);

    // Same-cycle priority: exception beats ertn and the CSR write
    bus.excp_flush = 1; bus.ertn_flush = 1; bus.csr_era = 32'h1c000200;
    bus.csr_wr_en = 1; bus.wr_csr_addr = 14'h006; bus.wr_csr_data = 32'hdeadbeef;
    do_cycle();
    expect_rd("era_priority", 14'h006, 32'hffffffff, 32'h1c000200);
    do_cycle();

    csr_write(14'h00c, 32'h1c00803f);
    expect_out("ex_entry_masked", 1, 32'h1c008000);
    expect_rd("unimpl_reads_zero", 14'h099, 32'hffffffff, 0);
    do_cycle();

    // KLO keeps llbit across ertn and self-clears
    csr_write(14'h060, 32'h4);
    bus.ws_llbit_set = 1; bus.ws_llbit = 1;
    do_cycle();
    bus.ertn_flush = 1;
    do_cycle();
    expect_rd("llbctl_klo_consumed", 14'h060, 32'hffffffff, 32'h1);
    do_cycle();

    // Reset overrides a simultaneous exception
    reset = 1; bus.excp_flush = 1; bus.csr_era = 32'hcafef00d;
    do_cycle();
    expect_rd("crmd_reset_override", 14'h000, 32'hffffffff, 32'h8);
    do_cycle();
    expect_rd("era_reset_override", 14'h006, 32'hffffffff, 0);
    do_cycle();

    bus.rd_csr_addr = 14'h000;
    #1;
    n_checks++;
    if (bus.rd_csr_data !== 32'h8) begin
      n_fail++;
      $display("FAIL direct_crmd: got %h expected %h", bus.rd_csr_data, 32'h8);
    end
    n_checks++;
    if (bus.plv !== 2'd0) begin
      n_fail++;
      $display("FAIL direct_plv: got %h expected %h", bus.plv, 2'd0);
    end
    n_checks++;
    if (bus.llbit !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_llbit: got %b expected %b", bus.llbit, 1'b0);
    end
    n_checks++;
    if (bus.ertn_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_ertn_pc: got %h expected %h", bus.ertn_pc, 32'h0);
    end
    n_checks++;
    if (bus.ex_entry !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_ex_entry: got %h expected %h", bus.ex_entry, 32'h0);
    end

    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      bus.hw_int      = 8'($urandom);
      bus.rd_csr_addr = addrs[$urandom_range(0, 11)];
      r = $urandom_range(0, 199);
      if (r == 0) reset = 1;
      if (r >= 1 && r < 9) begin
        bus.excp_flush   = 1;
        bus.csr_era      = $urandom;
        bus.csr_ecode    = 6'($urandom);
        bus.csr_esubcode = 9'($urandom);
        bus.va_error     = 1'($urandom);
        bus.bad_va       = $urandom;
      end
      if (r >= 6 && r < 16) bus.ertn_flush = 1;
      if ($urandom_range(0, 2) == 0) begin
        bus.csr_wr_en   = 1;
        bus.wr_csr_addr = addrs[$urandom_range(0, 11)];
        bus.wr_csr_data = (bus.wr_csr_addr == 14'h041) ?
                          (($urandom_range(0, 6) << 2) | $urandom_range(0, 3)) : $urandom;
      end
      if (!bus.ertn_flush && $urandom_range(0, 9) == 0) begin
        bus.ws_llbit_set = 1;
        bus.ws_llbit     = 1'($urandom);
      end
      do_cycle();
    end

    @(negedge clk);
    #1;
    if (n_fail != 0) $display("FAIL summary: got %0d failures expected 0", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have ports: clk in 1, system clock; reset in 1, synchronous active-high reset.
REQ-002 excp_flush in 1 (exception commit); ertn_flush in 1 (ertn commit); csr_era in 32 (faulting pc); csr_ecode in 6; csr_esubcode in 9; va_error in 1; bad_va in 32.
REQ-003 csr_wr_en in 1; wr_csr_addr in 14; wr_csr_data in 32 (final value, masking done upstream).
REQ-004 ws_llbit_set in 1; ws_llbit in 1; hw_int in 8 (level external interrupts).
REQ-005 rd_csr_addr in 14; rd_csr_data out 32 (combinational read port).
REQ-006 ex_entry out 32; ertn_pc out 32; has_int out 1; llbit out 1; plv out 2.

Function
REQ-007 Implemented CSRs: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xc, TCFG 0x41, TVAL 0x42, TICLR 0x44, LLBCTL 0x60; all other addresses read 0, writes ignored.
REQ-008 Field map: CRMD PLV[1:0] IE[2] DA[3] PG[4]; PRMD PPLV[1:0] PIE[2]; ECFG LIE[12:0], bit10 hardwired 0; ESTAT IS[12:0], Ecode[21:16], EsubCode[30:22]; EENTRY [31:6] writable, [5:0]=0; TCFG En[0] Periodic[1] InitVal[31:2]; unlisted bits read 0.
REQ-009 Write side effects: ESTAT write updates only IS[1:0]; TVAL read-only; TICLR write with bit0=1 clears IS[11], TICLR reads 0; LLBCTL write WCLLB[1]=1 clears llbit, KLO[2] writable, ROLLB[0] reads llbit.
REQ-010 ESTAT.IS[9:2] register hw_int every cycle (one-cycle latency); IS[12]=0.
REQ-011 Exception entry (excp_flush=1): PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ERA<=csr_era, ESTAT.Ecode<=csr_ecode, ESTAT.EsubCode<=csr_esubcode; BADV<=bad_va only if va_error=1.
REQ-012 ertn (ertn_flush=1): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; if LLBCTL.KLO=0 llbit<=0, else KLO<=0 and llbit unchanged.
REQ-013 Same-cycle priority: excp_flush > ertn_flush > csr_wr_en; lower-priority events that cycle are dropped entirely.
REQ-014 ws_llbit_set=1 loads llbit<=ws_llbit; same cycle as WCLLB write: ws_llbit_set wins.
REQ-015 ex_entry=EENTRY, ertn_pc=ERA, plv=CRMD.PLV, llbit = llbit register; all combinational from current register state.
REQ-016 has_int = CRMD.IE & |(ESTAT.IS & ECFG.LIE), combinational.
REQ-017 Timer: TCFG write loads TVAL<={InitVal,2'b00}; otherwise while En=1 and TVAL!=0 TVAL decrements by 1 per cycle.
REQ-018 Timer expiry: on the cycle TVAL=1 with En=1, set IS[11]; one-shot: TVAL->0 and stays; periodic: TVAL<={InitVal,2'b00}.
REQ-019 TICLR clear and expiry in same cycle: IS[11] ends set (expiry wins).
REQ-020 Read during write to same address returns old value; new value visible next cycle.

Reset
REQ-021 On reset: CRMD=0x00000008 (DA=1), PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TCFG, TVAL, LLBCTL all 0; llbit=0; outputs reflect these values the cycle after reset.
REQ-022 Reset overrides every same-cycle event, including excp_flush and timer expiry.

Verification
REQ-023 CRMD=0x7 (PLV3,IE1), excp_flush ecode=0x0B era=0x1c000100 -> next cycle CRMD.PLV=0 IE=0, PRMD=0x7, ERA=0x1c000100, ESTAT[21:16]=0x0B, BADV unchanged.
REQ-024 Then ertn_flush with KLO=0, llbit=1 -> CRMD.PLV=3 IE=1, llbit=0, ertn_pc=0x1c000100.
REQ-025 TCFG write 0x0000000B (InitVal=2, periodic, En) -> TVAL=8, counts to 1, IS[11]=1, TVAL reloads 8; TICLR write 1 -> IS[11]=0.
REQ-026 ECFG.LIE=0x800, CRMD.IE=1, timer expiry -> has_int=1; CRMD.IE=0 -> has_int=0.
REQ-027 excp_flush, ertn_flush and csr_wr_en to ERA in same cycle -> only exception updates applied, ERA=csr_era.
REQ-028 EENTRY write 0x1c00803f -> ex_entry=0x1c008000; read address 0x99 -> 0.
